// File: rtl/pipelined_addsub_pkg.sv
// addsub_pkg: operation/flag types and operand-conditioning helpers for pipelined_addsub
package addsub_pkg;

    typedef enum logic [1:0] {
        ADD = 2'd0,
        SUB = 2'd1,
        ADC = 2'd2,
        SBC = 2'd3
    } op_t;

    typedef struct packed {
        logic v;
        logic c;
        logic z;
        logic n;
    } flags_t;

    localparam int FLAG_V = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    function automatic logic op_is_sub(op_t op);
        return op == SUB || op == SBC;
    endfunction

    // Subtraction is A + ~B + 1, so SUB forces the carry in and SBC uses cin as "not borrow"
    function automatic logic op_carry_in(op_t op, logic cin);
        return (op == ADC || op == SBC) ? cin : op == SUB;
    endfunction

endpackage

// File: rtl/pipelined_addsub_if.sv
// pipelined_addsub_if: operand and result valid/ready bus of pipelined_addsub
interface pipelined_addsub_if #(
    parameter int WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    addsub_pkg::op_t      in_op;
    logic                 in_cin;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_sum;
    addsub_pkg::flags_t   out_flags;

    modport master (
        output in_valid, in_op, in_cin, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_sum, out_flags
    );

    modport slave (
        input  in_valid, in_op, in_cin, in_a, in_b, out_ready,
        output in_ready, out_valid, out_sum, out_flags
    );
endinterface

// File: rtl/pipelined_addsub_cla_group.sv
// cla_group: GROUP-bit carry-lookahead adder slice, also exposing the carry into its MSB
module cla_group #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] i_a,
    input  logic [GROUP-1:0] i_b,
    input  logic             i_cin,
    output logic [GROUP-1:0] o_s,
    output logic             o_cout,
    output logic             o_c_msb_in
);
    logic [GROUP-1:0] w_g;
    logic [GROUP-1:0] w_p;
    logic [GROUP:0]   w_c;
    logic             w_prop;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // Each carry is a flat sum of products of generate/propagate terms, not a ripple chain
    always_comb begin
        w_c    = '0;
        w_prop = 1'b1;
        w_c[0] = i_cin;
        for (int i = 1; i <= GROUP; i++) begin
            w_prop = 1'b1;
            for (int j = i - 1; j >= 0; j--) begin
                w_c[i] = w_c[i] | (w_g[j] & w_prop);
                w_prop = w_prop & w_p[j];
            end
            w_c[i] = w_c[i] | (w_prop & i_cin);
        end
    end

    assign o_s        = w_p ^ w_c[GROUP-1:0];
    assign o_cout     = w_c[GROUP];
    assign o_c_msb_in = w_c[GROUP-1];
endmodule

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: pipelined add/subtract with V/C/Z/N flags; the carry crosses one
// register per stage while operands and partial results travel with the beat.
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH            = 16,
    parameter int GROUP            = 4,
    parameter int GROUPS_PER_STAGE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    pipelined_addsub_if.slave  bus
);
    localparam int S   = GROUP * GROUPS_PER_STAGE;
    localparam int LAT = WIDTH / S;

    if (WIDTH % S != 0 || LAT < 1) begin : g_bad_width
        $error("pipelined_addsub: WIDTH must be a non-zero multiple of GROUP*GROUPS_PER_STAGE");
    end

    logic             w_adv;
    logic             w_cin0;
    logic [WIDTH-1:0] w_b0;

    // The whole pipe moves together; a held output freezes every stage, bubbles included
    assign w_adv        = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = w_adv;
    assign w_cin0       = op_carry_in(bus.in_op, bus.in_cin);
    assign w_b0         = op_is_sub(bus.in_op) ? ~bus.in_b : bus.in_b;

    for (genvar k = 0; k < LAT; k++) begin : g_stage
        logic                        r_valid;
        logic                        r_carry;
        logic                        r_v;
        logic                        r_z;
        logic [WIDTH-1:0]            r_a;
        logic [WIDTH-1:0]            r_b;
        logic [WIDTH-1:0]            r_sum;
        logic                        w_valid;
        logic                        w_z_in;
        logic [WIDTH-1:0]            w_a;
        logic [WIDTH-1:0]            w_b;
        logic [WIDTH-1:0]            w_sum_in;
        logic [GROUPS_PER_STAGE:0]   w_c;
        logic [GROUPS_PER_STAGE-1:0] w_cm;
        logic [S-1:0]                w_s;

        if (k == 0) begin : g_first
            assign w_valid  = bus.in_valid;
            assign w_a      = bus.in_a;
            assign w_b      = w_b0;
            assign w_c[0]   = w_cin0;
            assign w_sum_in = '0;
            assign w_z_in   = 1'b1;
        end else begin : g_next
            assign w_valid  = g_stage[k-1].r_valid;
            assign w_a      = g_stage[k-1].r_a;
            assign w_b      = g_stage[k-1].r_b;
            assign w_c[0]   = g_stage[k-1].r_carry;
            assign w_sum_in = g_stage[k-1].r_sum;
            assign w_z_in   = g_stage[k-1].r_z;
        end

        for (genvar g = 0; g < GROUPS_PER_STAGE; g++) begin : g_grp
            cla_group #(.GROUP(GROUP)) u_cla (
                .i_a        (w_a[k*S + g*GROUP +: GROUP]),
                .i_b        (w_b[k*S + g*GROUP +: GROUP]),
                .i_cin      (w_c[g]),
                .o_s        (w_s[g*GROUP +: GROUP]),
                .o_cout     (w_c[g+1]),
                .o_c_msb_in (w_cm[g])
            );
        end

        // Only the last stage's overflow bit is meaningful; it is the stage that owns the MSB
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_valid <= 1'b0;
                r_carry <= 1'b0;
                r_v     <= 1'b0;
                r_z     <= 1'b0;
                r_a     <= '0;
                r_b     <= '0;
                r_sum   <= '0;
            end else if (w_adv) begin
                r_valid <= w_valid;
                r_carry <= w_c[GROUPS_PER_STAGE];
                r_v     <= w_c[GROUPS_PER_STAGE] ^ w_cm[GROUPS_PER_STAGE-1];
                r_z     <= w_z_in && (w_s == '0);
                r_a     <= w_a;
                r_b     <= w_b;
                r_sum   <= w_sum_in | (WIDTH'(w_s) << (k * S));
            end
        end
    end

    assign bus.out_valid = g_stage[LAT-1].r_valid;
    assign bus.out_sum   = g_stage[LAT-1].r_sum;
    assign bus.out_flags = flags_t'{
        v: g_stage[LAT-1].r_v,
        c: g_stage[LAT-1].r_carry,
        z: g_stage[LAT-1].r_z,
        n: g_stage[LAT-1].r_sum[WIDTH-1]
    };
endmodule
